// File: rtl/pulse_sequencer.sv
// Repeating P1 / P2-train pulse generator driving RF gate, receiver blank and scope sync.
// Optional CPMG multi-echo train is enabled by defining PULSE_SEQ_CPMG_EN.
//
// state | meaning
// IDLE  | out of reset, waiting for the first period start
// P1    | excitation pulse
// DEL   | P1-end to first-P2 delay
// P2    | refocusing pulse
// GAP   | 2*del spacing between consecutive P2 pulses
// DONE  | sequence finished, waiting for the next period start

module pulse_sequencer #(
    parameter int unsigned PER_MIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] per,
    input  logic [15:0] p1wid,
    input  logic [15:0] del,
    input  logic [15:0] p2wid,
    input  logic [7:0]  cp,
    input  logic [7:0]  p_bl,
    input  logic        bl,
    output logic        sync,
    output logic        pulse,
    output logic        inhib,
    output logic [7:0]  echo_num
);

`ifdef PULSE_SEQ_CPMG_EN
    localparam bit CPMG_EN = 1'b1;
`else
    localparam bit CPMG_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, P1, DEL, P2, GAP, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] per_l, per_nx;
    logic [15:0] p1wid_l, p1wid_nx;
    logic [15:0] del_l, del_nx;
    logic [15:0] p2wid_l, p2wid_nx;
    logic [7:0]  cp_l, cp_nx;
    logic [7:0]  p_bl_l, p_bl_nx;
    logic        bl_l, bl_nx;

    logic [31:0] cnt, cnt_nx;
    logic [16:0] seg, seg_nx;
    logic        seg_on, seg_on_nx;
    logic [7:0]  tail, tail_nx;
    logic [7:0]  echo_nx;
    logic        started;

    logic [31:0] per_eff;
    logic        start;
    logic        pulse_end;
    logic        active_nx;
    logic [7:0]  n_p2;
    logic [7:0]  echo_inc;

    // Remaining-cycle count after the first cycle of a segment; zero length still lasts one cycle.
    function automatic logic [16:0] seg_load(input logic [16:0] len);
        return (len == 17'd0) ? 17'd0 : len - 17'd1;
    endfunction

    assign per_eff   = (per_l < 32'(PER_MIN)) ? 32'(PER_MIN) : per_l;
    assign start     = !started || (cnt == per_eff - 32'd1);
    assign n_p2      = CPMG_EN ? cp_l : 8'd1;
    assign echo_inc  = (echo_num == 8'hFF) ? 8'hFF : echo_num + 8'd1;
    assign pulse_end = ((state == P1) || (state == P2)) && seg_on && ((seg == 17'd0) || start);
    assign active_nx = ((state_nx == P1) || (state_nx == P2)) && seg_on_nx;

    always_comb begin
        per_nx    = per_l;
        p1wid_nx  = p1wid_l;
        del_nx    = del_l;
        p2wid_nx  = p2wid_l;
        cp_nx     = cp_l;
        p_bl_nx   = p_bl_l;
        bl_nx     = bl_l;
        cnt_nx    = cnt + 32'd1;
        state_nx  = state;
        seg_nx    = seg;
        seg_on_nx = seg_on;
        echo_nx   = echo_num;

        if (start) begin
            per_nx    = per;
            p1wid_nx  = p1wid;
            del_nx    = del;
            p2wid_nx  = p2wid;
            cp_nx     = cp;
            p_bl_nx   = p_bl;
            bl_nx     = bl;
            cnt_nx    = 32'd0;
            state_nx  = P1;
            seg_nx    = seg_load({1'b0, p1wid});
            seg_on_nx = (p1wid != 16'd0);
            echo_nx   = 8'd0;
        end else if (seg != 17'd0) begin
            seg_nx = seg - 17'd1;
        end else begin
            case (state)
                P1: begin
                    seg_on_nx = 1'b0;
                    if (n_p2 == 8'd0) begin
                        state_nx = DONE;
                        seg_nx   = 17'd0;
                    end else begin
                        state_nx = DEL;
                        seg_nx   = seg_load({1'b0, del_l});
                    end
                end
                DEL, GAP: begin
                    state_nx  = P2;
                    seg_nx    = seg_load({1'b0, p2wid_l});
                    seg_on_nx = (p2wid_l != 16'd0);
                end
                P2: begin
                    echo_nx   = echo_inc;
                    seg_on_nx = 1'b0;
                    if (echo_inc < n_p2) begin
                        state_nx = GAP;
                        seg_nx   = seg_load({del_l, 1'b0});
                    end else begin
                        state_nx = DONE;
                        seg_nx   = 17'd0;
                    end
                end
                default: begin
                    state_nx = state;
                end
            endcase
        end
    end

    // Tail reloads whenever a non-zero pulse ends, including truncation at a period wrap.
    assign tail_nx = pulse_end ? p_bl_l : ((tail != 8'd0) ? tail - 8'd1 : 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            per_l    <= 32'd0;
            p1wid_l  <= 16'd0;
            del_l    <= 16'd0;
            p2wid_l  <= 16'd0;
            cp_l     <= 8'd0;
            p_bl_l   <= 8'd0;
            bl_l     <= 1'b0;
            cnt      <= 32'd0;
            seg      <= 17'd0;
            seg_on   <= 1'b0;
            tail     <= 8'd0;
            started  <= 1'b0;
            sync     <= 1'b0;
            pulse    <= 1'b0;
            inhib    <= 1'b0;
            echo_num <= 8'd0;
        end else begin
            state    <= state_nx;
            per_l    <= per_nx;
            p1wid_l  <= p1wid_nx;
            del_l    <= del_nx;
            p2wid_l  <= p2wid_nx;
            cp_l     <= cp_nx;
            p_bl_l   <= p_bl_nx;
            bl_l     <= bl_nx;
            cnt      <= cnt_nx;
            seg      <= seg_nx;
            seg_on   <= seg_on_nx;
            tail     <= tail_nx;
            started  <= 1'b1;
            sync     <= start;
            pulse    <= active_nx && !bl_nx;
            inhib    <= active_nx || (tail_nx != 8'd0);
            echo_num <= echo_nx;
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: per-cycle {sync,pulse,inhib,echo_num} against
// window expectations built from the closed-form pulse timing.

module tb_pulse_sequencer;

`ifdef PULSE_SEQ_CPMG_EN
    localparam bit CPMG = 1'b1;
`else
    localparam bit CPMG = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] per;
    logic [15:0] p1wid, del, p2wid;
    logic [7:0]  cp, p_bl;
    logic        bl;
    logic        sync, pulse, inhib;
    logic [7:0]  echo_num;

    int vectors     = 0;
    int miscompares = 0;
    logic [10:0] cap [0:511];
    logic [10:0] exp_v;

    pulse_sequencer #(.PER_MIN(2)) dut (
        .clk(clk), .rst_n(rst_n), .per(per), .p1wid(p1wid), .del(del),
        .p2wid(p2wid), .cp(cp), .p_bl(p_bl), .bl(bl),
        .sync(sync), .pulse(pulse), .inhib(inhib), .echo_num(echo_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {sync,pulse,inhib,echo_num} at period cycle c; k-th P2 starts at p1+d+(k-1)(p2+2d).
    function automatic logic [10:0] exp_vec(input int c, input int p1w, input int d,
                                            input int p2w, input int n, input int pbl,
                                            input bit b);
        int p1  = (p1w != 0) ? p1w : 1;
        int dd  = (d != 0) ? d : 1;
        int p2  = (p2w != 0) ? p2w : 1;
        int gap = (d != 0) ? 2 * d : 1;
        int s;
        int e   = 0;
        logic pu = (p1w != 0) && (c < p1);
        logic ih = (p1w != 0) && (c < p1 + pbl);
        for (int k = 0; k < n; k++) begin
            s = p1 + dd + k * (p2 + gap);
            if (p2w != 0 && c >= s && c < s + p2) pu = 1'b1;
            if (p2w != 0 && c >= s && c < s + p2 + pbl) ih = 1'b1;
            if (c >= s + p2) e++;
        end
        return {c == 0, pu && !b, ih, 8'(e)};
    endfunction

    function automatic int n_eff(input int c);
        return CPMG ? c : 1;
    endfunction

    task automatic start_seq(input logic [31:0] pr, input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] b2, input logic [7:0] c, input logic [7:0] pb,
                             input logic b);
        rst_n = 1'b0;
        per = pr; p1wid = a; del = d; p2wid = b2; cp = c; p_bl = pb; bl = b;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cap[base + i] = {sync, pulse, inhib, echo_num};
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        per = 32'd100; p1wid = 16'd9; del = 16'd20; p2wid = 16'd18; cp = 8'd1; p_bl = 8'd5; bl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({sync, pulse, inhib, echo_num} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset cycle %0d got %h exp 000", i, {sync, pulse, inhib, echo_num});
            end
        end
    endtask

    task automatic test_basic;
        start_seq(32'd100, 16'd9, 16'd20, 16'd18, 8'd1, 8'd5, 1'b0);
        run(0, 210);
        for (int k = 0; k < 210; k++) begin
            exp_v = exp_vec(k % 100, 9, 20, 18, 1, 5, 1'b0);
            vectors++;
            if (cap[k] !== exp_v) begin
                miscompares++;
                $display("FAIL basic cycle %0d got %h exp %h", k, cap[k], exp_v);
            end
        end
    endtask

    task automatic test_blank;
        start_seq(32'd100, 16'd9, 16'd20, 16'd18, 8'd1, 8'd5, 1'b1);
        run(0, 200);
        for (int k = 0; k < 200; k++) begin
            exp_v = exp_vec(k % 100, 9, 20, 18, 1, 5, 1'b1);
            vectors++;
            if (cap[k] !== exp_v) begin
                miscompares++;
                $display("FAIL blank cycle %0d got %h exp %h", k, cap[k], exp_v);
            end
        end
    endtask

    task automatic test_cpmg;
        start_seq(32'd250, 16'd9, 16'd20, 16'd18, 8'd3, 8'd5, 1'b0);
        run(0, 250);
        for (int k = 0; k < 250; k++) begin
            exp_v = exp_vec(k, 9, 20, 18, n_eff(3), 5, 1'b0);
            vectors++;
            if (cap[k] !== exp_v) begin
                miscompares++;
                $display("FAIL cpmg cycle %0d got %h exp %h", k, cap[k], exp_v);
            end
        end
    endtask

    task automatic test_truncate;
        start_seq(32'd150, 16'd9, 16'd20, 16'd18, 8'd3, 8'd5, 1'b0);
        run(0, 300);
        for (int k = 0; k < 300; k++) begin
            exp_v = exp_vec(k % 150, 9, 20, 18, n_eff(3), 5, 1'b0);
            vectors++;
            if (cap[k] !== exp_v) begin
                miscompares++;
                $display("FAIL truncate cycle %0d got %h exp %h", k, cap[k], exp_v);
            end
        end
    endtask

    task automatic test_cp_zero;
        start_seq(32'd100, 16'd9, 16'd20, 16'd18, 8'd0, 8'd5, 1'b0);
        run(0, 100);
        for (int k = 0; k < 100; k++) begin
            exp_v = exp_vec(k, 9, 20, 18, n_eff(0), 5, 1'b0);
            vectors++;
            if (cap[k] !== exp_v) begin
                miscompares++;
                $display("FAIL cp_zero cycle %0d got %h exp %h", k, cap[k], exp_v);
            end
        end
    endtask

    task automatic test_del_change;
        start_seq(32'd100, 16'd9, 16'd20, 16'd18, 8'd1, 8'd5, 1'b0);
        run(0, 30);
        del = 16'd40;
        run(30, 170);
        for (int k = 0; k < 200; k++) begin
            exp_v = exp_vec(k % 100, 9, (k < 100) ? 20 : 40, 18, 1, 5, 1'b0);
            vectors++;
            if (cap[k] !== exp_v) begin
                miscompares++;
                $display("FAIL del_change cycle %0d got %h exp %h", k, cap[k], exp_v);
            end
        end
    endtask

    task automatic test_clamp;
        start_seq(32'd1, 16'd0, 16'd20, 16'd0, 8'd1, 8'd5, 1'b0);
        run(0, 20);
        for (int k = 0; k < 20; k++) begin
            exp_v = exp_vec(k % 2, 0, 20, 0, 1, 5, 1'b0);
            vectors++;
            if (cap[k] !== exp_v) begin
                miscompares++;
                $display("FAIL clamp cycle %0d got %h exp %h", k, cap[k], exp_v);
            end
        end
    endtask

    task automatic test_mid_reset;
        start_seq(32'd100, 16'd9, 16'd20, 16'd18, 8'd1, 8'd5, 1'b0);
        run(0, 36);
        for (int k = 0; k < 36; k++) begin
            exp_v = exp_vec(k, 9, 20, 18, 1, 5, 1'b0);
            vectors++;
            if (cap[k] !== exp_v) begin
                miscompares++;
                $display("FAIL pre_reset cycle %0d got %h exp %h", k, cap[k], exp_v);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({sync, pulse, inhib, echo_num} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset got %h exp 000", {sync, pulse, inhib, echo_num});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 100);
        for (int k = 0; k < 100; k++) begin
            exp_v = exp_vec(k, 9, 20, 18, 1, 5, 1'b0);
            vectors++;
            if (cap[k] !== exp_v) begin
                miscompares++;
                $display("FAIL post_reset cycle %0d got %h exp %h", k, cap[k], exp_v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        per = 32'd0; p1wid = 16'd0; del = 16'd0; p2wid = 16'd0;
        cp = 8'd0; p_bl = 8'd0; bl = 1'b0;
        test_reset();
        test_basic();
        test_blank();
        test_cpmg();
        test_truncate();
        test_cp_zero();
        test_del_change();
        test_clamp();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
